apb_slave_mem: RTL and testbench
================================

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter MEM_DEPTH, default 64: number of 8-bit storage locations, mapped at addresses 0x00..MEM_DEPTH-1.
REQ-002 Parameter WAIT_CYCLES, default 1: number of wait states inserted in every access phase (range 0..15).
REQ-003 Parameter ID_VALUE, default 8'hA5: read-only identification byte, located at address MEM_DEPTH.
REQ-004 PCLK  input  1  APB clock; all state changes on its rising edge.
REQ-005 PRESETn  input  1  reset: PRESETn, asynchronous, active-low.
REQ-006 PSEL  input  1  slave select from the bridge.
REQ-007 PENABLE  input  1  access-phase indicator.
REQ-008 PADDR  input  8  byte address (bit 8 of the bridge address is the slave decode and is not connected).
REQ-009 PWRITE  input  1  1=write, 0=read.
REQ-010 PWDATA  input  8  write data.
REQ-011 PREADY  output  1  transfer-complete indication, registered.
REQ-012 PRDATA  output  8  read data, registered.
REQ-013 PSLVERR  output  1  transfer error, registered.
REQ-014 protocol_err  output  1  one-cycle pulse flagging a master protocol violation.

Function
REQ-015 FSM states: IDLE, ACCESS; any unused encoding SHALL return to IDLE.
REQ-016 IDLE: a cycle with PSEL=1 and PENABLE=0 (setup) SHALL latch PADDR, PWRITE and PWDATA, load the wait counter with WAIT_CYCLES, and move to ACCESS.
REQ-017 All decode, write and read actions SHALL use the latched values; input changes during ACCESS SHALL be ignored.
REQ-018 PREADY SHALL be 1 in exactly one access cycle per transfer: access cycle number WAIT_CYCLES+1, counted from the first cycle with PENABLE=1; with WAIT_CYCLES=0 this is the first access cycle (zero-wait).
REQ-019 The completion cycle is PSEL=1, PENABLE=1, PREADY=1; at its closing edge the FSM SHALL return to IDLE and PREADY SHALL drop to 0.
REQ-020 Back-to-back: a setup cycle immediately after completion SHALL start a new transfer with no idle cycle required.
REQ-021 Address decode: address < MEM_DEPTH selects memory; address = MEM_DEPTH selects the ID register; address > MEM_DEPTH is unmapped.
REQ-022 A memory write SHALL update the latched location at the closing edge of the completion cycle only.
REQ-023 Read: PRDATA SHALL present the memory byte or ID_VALUE during the completion cycle; outside completion cycles, and for an erroring read, PRDATA SHALL be 0x00.
REQ-024 PSLVERR SHALL be 1 only in the completion cycle of a write to the ID register or any access to an unmapped address; it is 0 in every other cycle.
REQ-025 An erroring write SHALL leave memory unchanged.
REQ-026 Abort: if PSEL=0 or PENABLE=0 in ACCESS before completion, the FSM SHALL return to IDLE with no write, PREADY=0, and protocol_err=1 for the next cycle.
REQ-027 A cycle with PSEL=1 and PENABLE=1 while in IDLE (no preceding setup) SHALL be ignored, except that protocol_err SHALL pulse for one cycle.
REQ-028 A read of a location in the same transfer sequence SHALL return data written by any earlier completed write.

Reset
REQ-029 While PRESETn=0: state=IDLE, PREADY=0, PRDATA=0x00, PSLVERR=0, protocol_err=0, wait counter=0, all memory locations=0x00.
REQ-030 Reset asserted mid-transfer SHALL abort that transfer immediately with no memory update; the first transfer after release SHALL behave normally.

Verification
REQ-031 WAIT_CYCLES=1: write 0x3C to addr 0x05, then read 0x05 -> write completes in 2nd access cycle, PSLVERR=0; read PRDATA=0x3C with PREADY.
REQ-032 WAIT_CYCLES=0: back-to-back writes to 0x00 and 0x3F (0x11, 0x22), then reads -> each completes in 1st access cycle; PRDATA=0x11 then 0x22.
REQ-033 Read addr 0x40 -> PRDATA=0xA5, PSLVERR=0; write 0x55 to 0x40 -> PSLVERR=1, then read 0x40 still returns 0xA5.
REQ-034 Read addr 0x80 -> PSLVERR=1, PRDATA=0x00; write 0x77 to 0xFF -> PSLVERR=1, memory contents unchanged.
REQ-035 WAIT_CYCLES=3: write to 0x10, PSEL dropped in 2nd access cycle -> protocol_err pulses once, addr 0x10 still reads 0x00; then change PADDR mid-access on a legal write -> write lands at the setup-phase address.
REQ-036 Assert PRESETn low during a wait state of a write to 0x08 -> PREADY=0, and after release addr 0x08 reads 0x00.

Source files
------------

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave with byte memory, read-only ID register and programmable wait states.
// Outputs are registered, so completion status is computed one edge ahead of the completion cycle.
module apb_slave_mem #(
    parameter int          MEM_DEPTH   = 64,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic [7:0] PADDR,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    output logic       PREADY,
    output logic [7:0] PRDATA,
    output logic       PSLVERR,
    output logic       protocol_err
);
    localparam int         AW      = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam logic [8:0] ID_ADDR = 9'(MEM_DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state;
    logic [7:0] addr, wdata, a, rdata;
    logic       write, w, is_mem, is_id, err, go;
    logic [3:0] cnt;
    logic [7:0] mem [MEM_DEPTH];

    // Decode the live bus during setup and the latched request during access.
    always_comb begin
        a      = (state == ACCESS) ? addr : PADDR;
        w      = (state == ACCESS) ? write : PWRITE;
        is_mem = {1'b0, a} < ID_ADDR;
        is_id  = {1'b0, a} == ID_ADDR;
        err    = !(is_mem || is_id) || (is_id && w);
        rdata  = (w || err) ? 8'h00 : is_id ? ID_VALUE : mem[a[AW-1:0]];
        go     = PSEL && PENABLE;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state        <= IDLE;
            {PREADY, PRDATA, PSLVERR} <= '0;
            protocol_err <= 1'b0;
            cnt          <= '0;
            addr         <= '0;
            wdata        <= '0;
            write        <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            protocol_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        addr  <= PADDR;
                        write <= PWRITE;
                        wdata <= PWDATA;
                        cnt   <= 4'(WAIT_CYCLES);
                        state <= ACCESS;
                        if (WAIT_CYCLES == 0) {PREADY, PRDATA, PSLVERR} <= {1'b1, rdata, err};
                    end else if (go) begin
                        protocol_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!go) begin
                        state        <= IDLE;
                        {PREADY, PRDATA, PSLVERR} <= '0;
                        protocol_err <= 1'b1;
                    end else if (PREADY) begin
                        state <= IDLE;
                        {PREADY, PRDATA, PSLVERR} <= '0;
                        if (write && !err) mem[addr[AW-1:0]] <= wdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) {PREADY, PRDATA, PSLVERR} <= {1'b1, rdata, err};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed APB transfers against three instances with 0, 1 and 3 wait states.
module tb_apb_slave_mem;
    logic       clk = 0, rst_n = 0, penable = 0, pwrite = 0;
    logic [2:0] psel_v = '0;
    logic [7:0] paddr = '0, pwdata = '0;
    logic [2:0] pready_v, pslverr_v, perr_v;
    logic [7:0] prdata_a [3];
    int         total = 0, bad = 0;
    int         waits [3] = '{0, 1, 3};

    always #5 clk = ~clk;

    apb_slave_mem #(.WAIT_CYCLES(0)) u_w0 (.PCLK(clk), .PRESETn(rst_n), .PSEL(psel_v[0]), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready_v[0]), .PRDATA(prdata_a[0]),
        .PSLVERR(pslverr_v[0]), .protocol_err(perr_v[0]));
    apb_slave_mem #(.WAIT_CYCLES(1)) u_w1 (.PCLK(clk), .PRESETn(rst_n), .PSEL(psel_v[1]), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready_v[1]), .PRDATA(prdata_a[1]),
        .PSLVERR(pslverr_v[1]), .protocol_err(perr_v[1]));
    apb_slave_mem #(.WAIT_CYCLES(3)) u_w3 (.PCLK(clk), .PRESETn(rst_n), .PSEL(psel_v[2]), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready_v[2]), .PRDATA(prdata_a[2]),
        .PSLVERR(pslverr_v[2]), .protocol_err(perr_v[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Setup starts at the next edge, so consecutive calls are back-to-back.
    task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                        input bit corrupt, output logic [7:0] rd, output logic er, output int n);
        @(posedge clk); #1;
        psel_v = '0; psel_v[d] = 1'b1; penable = 0; pwrite = w; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1;
        if (corrupt) begin paddr = a + 8'd1; pwdata = ~wd; end
        n = 0; rd = 8'hxx; er = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (pready_v[d]) begin rd = prdata_a[d]; er = pslverr_v[d]; break; end
            chk("wait_prdata", {24'd0, prdata_a[d]}, 32'h00);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel_v = '0; penable = 0;
    endtask

    task automatic wr(input int d, input logic [7:0] a, input logic [7:0] wd, input logic exp_err, input bit corrupt);
        logic [7:0] r; logic e; int n;
        xfer(d, 1'b1, a, wd, corrupt, r, e, n);
        chk($sformatf("wr_cyc[%0d]@%0h", d, a), n, waits[d] + 1);
        chk($sformatf("wr_err[%0d]@%0h", d, a), {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rd(input int d, input logic [7:0] a, input logic [7:0] exp_d, input logic exp_err);
        logic [7:0] r; logic e; int n;
        xfer(d, 1'b0, a, 8'h00, 1'b0, r, e, n);
        chk($sformatf("rd_cyc[%0d]@%0h", d, a), n, waits[d] + 1);
        chk($sformatf("rd_data[%0d]@%0h", d, a), {24'd0, r}, {24'd0, exp_d});
        chk($sformatf("rd_err[%0d]@%0h", d, a), {31'd0, e}, {31'd0, exp_err});
    endtask

    initial begin
        int pulses;
        repeat (2) @(negedge clk);
        chk("rst_pready", {29'd0, pready_v}, 0);
        chk("rst_pslverr", {29'd0, pslverr_v}, 0);
        chk("rst_perr", {29'd0, perr_v}, 0);
        chk("rst_prdata", {8'd0, prdata_a[0], prdata_a[1], prdata_a[2]}, 0);
        @(posedge clk); #1 rst_n = 1;

        wr(1, 8'h05, 8'h3C, 1'b0, 1'b0);
        rd(1, 8'h05, 8'h3C, 1'b0);
        idle();

        wr(0, 8'h00, 8'h11, 1'b0, 1'b0);
        wr(0, 8'h3F, 8'h22, 1'b0, 1'b0);
        rd(0, 8'h00, 8'h11, 1'b0);
        rd(0, 8'h3F, 8'h22, 1'b0);
        idle();
        @(negedge clk);
        chk("post_pready0", {31'd0, pready_v[0]}, 0);
        chk("post_prdata0", {24'd0, prdata_a[0]}, 0);

        rd(1, 8'h40, 8'hA5, 1'b0);
        wr(1, 8'h40, 8'h55, 1'b1, 1'b0);
        rd(1, 8'h40, 8'hA5, 1'b0);
        rd(1, 8'h80, 8'h00, 1'b1);
        wr(1, 8'hFF, 8'h77, 1'b1, 1'b0);
        rd(1, 8'h05, 8'h3C, 1'b0);
        rd(1, 8'h3F, 8'h00, 1'b0);
        idle();

        // Access phase without a setup phase
        @(posedge clk); #1 psel_v = 3'b001; penable = 1;
        @(posedge clk); #1 psel_v = '0; penable = 0;
        @(negedge clk);
        chk("idle_en_perr", {31'd0, perr_v[0]}, 1);
        chk("idle_en_pready", {31'd0, pready_v[0]}, 0);
        @(negedge clk);
        chk("idle_en_perr_clr", {31'd0, perr_v[0]}, 0);

        // Abort: PSEL dropped in the 2nd access cycle
        @(posedge clk); #1 psel_v = 3'b100; penable = 0; pwrite = 1; paddr = 8'h10; pwdata = 8'h99;
        @(posedge clk); #1 penable = 1;
        @(posedge clk); #1 psel_v = '0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (perr_v[2]) pulses++;
            if (pready_v[2]) pulses += 100;
        end
        chk("abort_pulses", pulses, 1);
        idle();
        rd(2, 8'h10, 8'h00, 1'b0);
        wr(2, 8'h20, 8'h5A, 1'b0, 1'b1);
        rd(2, 8'h20, 8'h5A, 1'b0);
        rd(2, 8'h21, 8'h00, 1'b0);
        idle();

        // Reset during a wait state
        @(posedge clk); #1 psel_v = 3'b010; penable = 0; pwrite = 1; paddr = 8'h08; pwdata = 8'h66;
        @(posedge clk); #1 penable = 1;
        @(negedge clk);
        chk("pre_rst_pready", {31'd0, pready_v[1]}, 0);
        rst_n = 0;
        #1;
        chk("mid_rst_pready", {31'd0, pready_v[1]}, 0);
        chk("mid_rst_prdata", {24'd0, prdata_a[1]}, 0);
        @(posedge clk); #1 psel_v = '0; penable = 0;
        @(posedge clk); #1 rst_n = 1;
        rd(1, 8'h08, 8'h00, 1'b0);
        wr(1, 8'h08, 8'hC3, 1'b0, 1'b0);
        rd(1, 8'h08, 8'hC3, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
